// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and axis-total helpers for the VGA timing generator.
// Pure definitions: no logic, no latency, no flow control.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_CW = 10;

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // A CW-bit counter must be able to hold total-1.
  function automatic bit width_fits(input int cw, input int total);
    return (cw < 31) && (total <= (1 << cw));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync decoded from the next count.
// Zero latency between count and sync; holds all state while adv is low.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  parameter bit POL    = 1'b0,
  parameter int CW     = VGA_CW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          adv,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          wrap,
  output logic          next_active
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_LAST   = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FP + SYNC - 1);

  logic [CW-1:0] count_nxt;
  logic          sync_nxt;

  // Decode from the value being loaded so sync lines up with count on the same cycle.
  always_comb begin
    wrap      = (count == LAST);
    count_nxt = count;
    if (adv) begin
      count_nxt = wrap ? '0 : count + CW'(1);
    end
    next_active = (count_nxt <= ACT_LAST);
    sync_nxt    = ((count_nxt >= SYNC_FIRST) && (count_nxt <= SYNC_LAST)) ? POL : !POL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      sync  <= !POL;
    end else if (adv) begin
      count <= count_nxt;
      sync  <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered hcount/vcount/hsync/vsync/active with zero mutual latency, plus line/frame pulses.
// enable low freezes everything; `VGA_TIMING_PIX_DIV_EN adds a PIX_DIV clock-per-pixel divider.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = VGA_CW,
  parameter int PIX_DIV  = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          pix_tick,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (!width_fits(CW, H_TOTAL)) begin : g_bad_cw_h
    $error("vga_timing_gen: CW=%0d cannot hold H_TOTAL-1=%0d", CW, H_TOTAL - 1);
  end
  if (!width_fits(CW, V_TOTAL)) begin : g_bad_cw_v
    $error("vga_timing_gen: CW=%0d cannot hold V_TOTAL-1=%0d", CW, V_TOTAL - 1);
  end
  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV=%0d must be at least 1", PIX_DIV);
  end

  logic adv;
  logic h_wrap;
  logic v_wrap;
  logic h_next_active;
  logic v_next_active;

`ifdef VGA_TIMING_PIX_DIV_EN
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_LAST) ? '0 : div + DW'(1);
    end
  end

  assign adv = enable && (div == DIV_LAST);
`else
  assign adv = enable;
`endif

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .CW     (CW)
  ) u_h_axis (
    .clock       (clock),
    .reset_n     (reset_n),
    .adv         (adv),
    .count       (hcount),
    .sync        (hsync),
    .wrap        (h_wrap),
    .next_active (h_next_active)
  );

  // The vertical axis steps only on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .CW     (CW)
  ) u_v_axis (
    .clock       (clock),
    .reset_n     (reset_n),
    .adv         (line_end),
    .count       (vcount),
    .sync        (vsync),
    .wrap        (v_wrap),
    .next_active (v_next_active)
  );

  // Cleared by reset and only reloaded on an advance, so pixel (0,0) of the first frame stays blanked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
    end else if (adv) begin
      active <= h_next_active && v_next_active;
    end
  end

  assign pix_tick  = adv;
  assign line_end  = adv && h_wrap;
  assign frame_end = line_end && v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x525 raster plus a 16x12 raster with active-high syncs for frame-level cases.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIX_DIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif
  localparam int D_LINE  = 800;
  localparam int S_FRAME = 16 * 12;
  localparam int NV      = 27;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [9:0] d_h, d_v;
  logic       d_hs, d_vs, d_act, d_pt, d_le, d_fe;
  logic [4:0] s_h, s_v;
  logic       s_hs, s_vs, s_act, s_pt, s_le, s_fe;

  always #5 clock = ~clock;

  vga_timing_gen #(.PIX_DIV(4)) u_dut_d (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs), .active(d_act),
    .pix_tick(d_pt), .line_end(d_le), .frame_end(d_fe)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(5), .PIX_DIV(4)
  ) u_dut_s (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs), .active(s_act),
    .pix_tick(s_pt), .line_end(s_le), .frame_end(s_fe)
  );

  typedef struct {
    bit sel;  // 0 = default raster, 1 = small raster
    int p;    // pixel position index since reset release
    int h;
    int v;
    bit hs;
    bit vs;
    bit act;
    bit le;
    bit fe;
  } vec_t;

  vec_t vecs[NV];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int t, cur, cnt_le, cnt_hs, cnt_pt, cnt_fe, bad;
    bit found;

    vecs[0]  = '{0,    0,   0, 0, 1, 1, 0, 0, 0};
    vecs[1]  = '{1,    0,   0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0,    1,   1, 0, 1, 1, 1, 0, 0};
    vecs[3]  = '{1,    7,   7, 0, 0, 0, 1, 0, 0};
    vecs[4]  = '{1,    8,   8, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1,   10,  10, 0, 1, 0, 0, 0, 0};
    vecs[6]  = '{1,   12,  12, 0, 1, 0, 0, 0, 0};
    vecs[7]  = '{1,   13,  13, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{1,   15,  15, 0, 0, 0, 0, 1, 0};
    vecs[9]  = '{1,   16,   0, 1, 0, 0, 1, 0, 0};
    vecs[10] = '{1,   95,  15, 5, 0, 0, 0, 1, 0};
    vecs[11] = '{1,   96,   0, 6, 0, 0, 0, 0, 0};
    vecs[12] = '{1,  112,   0, 7, 0, 1, 0, 0, 0};
    vecs[13] = '{1,  143,  15, 8, 0, 1, 0, 1, 0};
    vecs[14] = '{1,  144,   0, 9, 0, 0, 0, 0, 0};
    vecs[15] = '{1,  191,  15, 11, 0, 0, 0, 1, 1};
    vecs[16] = '{1,  192,   0, 0, 0, 0, 1, 0, 0};
    vecs[17] = '{0,  639, 639, 0, 1, 1, 1, 0, 0};
    vecs[18] = '{0,  640, 640, 0, 1, 1, 0, 0, 0};
    vecs[19] = '{0,  655, 655, 0, 1, 1, 0, 0, 0};
    vecs[20] = '{0,  656, 656, 0, 0, 1, 0, 0, 0};
    vecs[21] = '{0,  751, 751, 0, 0, 1, 0, 0, 0};
    vecs[22] = '{0,  752, 752, 0, 1, 1, 0, 0, 0};
    vecs[23] = '{0,  799, 799, 0, 1, 1, 0, 1, 0};
    vecs[24] = '{0,  800,   0, 1, 1, 1, 1, 0, 0};
    vecs[25] = '{0, 1599, 799, 1, 1, 1, 0, 1, 0};
    vecs[26] = '{0, 1600,   0, 2, 1, 1, 1, 0, 0};

    reset_n = 1'b1;
    enable  = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst.d_h", int'(d_h), 0);
    check("rst.d_hs", int'(d_hs), 1);
    check("rst.d_act", int'(d_act), 0);
    check("rst.s_hs", int'(s_hs), 0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_held.d_h", int'(d_h), 0);
    @(negedge clock) reset_n = 1'b1;
    cur = 0;

    // Sample each vector on the clock that carries the advance out of position p.
    for (int i = 0; i < NV; i++) begin
      t = vecs[i].p * DIV + DIV - 1;
      repeat (t - cur) @(posedge clock);
      #1;
      cur = t;
      if (!vecs[i].sel) begin
        check($sformatf("vec%0d.h", i),   int'(d_h),   vecs[i].h);
        check($sformatf("vec%0d.v", i),   int'(d_v),   vecs[i].v);
        check($sformatf("vec%0d.hs", i),  int'(d_hs),  int'(vecs[i].hs));
        check($sformatf("vec%0d.vs", i),  int'(d_vs),  int'(vecs[i].vs));
        check($sformatf("vec%0d.act", i), int'(d_act), int'(vecs[i].act));
        check($sformatf("vec%0d.le", i),  int'(d_le),  int'(vecs[i].le));
        check($sformatf("vec%0d.fe", i),  int'(d_fe),  int'(vecs[i].fe));
        check($sformatf("vec%0d.pt", i),  int'(d_pt),  1);
      end else begin
        check($sformatf("vec%0d.h", i),   int'(s_h),   vecs[i].h);
        check($sformatf("vec%0d.v", i),   int'(s_v),   vecs[i].v);
        check($sformatf("vec%0d.hs", i),  int'(s_hs),  int'(vecs[i].hs));
        check($sformatf("vec%0d.vs", i),  int'(s_vs),  int'(vecs[i].vs));
        check($sformatf("vec%0d.act", i), int'(s_act), int'(vecs[i].act));
        check($sformatf("vec%0d.le", i),  int'(s_le),  int'(vecs[i].le));
        check($sformatf("vec%0d.fe", i),  int'(s_fe),  int'(vecs[i].fe));
        check($sformatf("vec%0d.pt", i),  int'(s_pt),  1);
      end
    end

    // One full line on the default raster, line_end to line_end.
    found = 1'b0;
    for (int i = 0; i < D_LINE * DIV + 8 && !found; i++) begin
      @(posedge clock);
      #1;
      found = d_le;
    end
    check("line.sync_found", int'(found), 1);
    cnt_le = 0; cnt_hs = 0; cnt_pt = 0;
    for (int i = 0; i < D_LINE * DIV; i++) begin
      @(posedge clock);
      #1;
      cnt_le += int'(d_le);
      cnt_hs += int'(!d_hs);
      cnt_pt += int'(d_pt);
    end
    check("line.le_count", cnt_le, 1);
    check("line.le_at_end", int'(d_le), 1);
    check("line.hs_low_clocks", cnt_hs, 96 * DIV);
    check("line.pix_ticks", cnt_pt, D_LINE);

    // One full frame on the small raster.
    found = 1'b0;
    for (int i = 0; i < S_FRAME * DIV + 8 && !found; i++) begin
      @(posedge clock);
      #1;
      found = s_fe;
    end
    check("frame.sync_found", int'(found), 1);
    cnt_fe = 0; cnt_le = 0;
    for (int i = 0; i < S_FRAME * DIV; i++) begin
      @(posedge clock);
      #1;
      cnt_fe += int'(s_fe);
      cnt_le += int'(s_le);
    end
    check("frame.fe_count", cnt_fe, 1);
    check("frame.fe_at_end", int'(s_fe), 1);
    check("frame.le_count", cnt_le, 12);

    // Freeze at hcount=300 for 10 clocks, right when an advance is due.
    found = 1'b0;
    for (int i = 0; i < D_LINE * DIV + 8 && !found; i++) begin
      @(posedge clock);
      #1;
      found = (d_h == 10'd300) && d_pt;
    end
    check("hold.found", int'(found), 1);
    enable = 1'b0;
    bad = 0; cnt_pt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      bad    += int'(d_h != 10'd300);
      cnt_pt += int'(d_pt) + int'(d_le) + int'(d_fe) + int'(s_pt);
    end
    check("hold.h_changed", bad, 0);
    check("hold.pulses", cnt_pt, 0);
    enable = 1'b1;
    @(posedge clock);
    #1;
    check("hold.resume_h", int'(d_h), 301);

    // Asynchronous reset mid-line at hcount=400.
    found = 1'b0;
    for (int i = 0; i < D_LINE * DIV + 8 && !found; i++) begin
      @(posedge clock);
      #1;
      found = (d_h == 10'd400);
    end
    check("arst.found", int'(found), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst.d_h", int'(d_h), 0);
    check("arst.d_v", int'(d_v), 0);
    check("arst.d_hs", int'(d_hs), 1);
    check("arst.d_vs", int'(d_vs), 1);
    check("arst.d_act", int'(d_act), 0);
    check("arst.s_h", int'(s_h), 0);
    check("arst.s_v", int'(s_v), 0);
    check("arst.s_hs", int'(s_hs), 0);
    check("arst.s_vs", int'(s_vs), 0);
    check("arst.s_act", int'(s_act), 0);
    repeat (3) @(posedge clock);
    #1;
    check("arst.held_h", int'(d_h), 0);
    @(negedge clock) reset_n = 1'b1;
    repeat (DIV) @(posedge clock);
    #1;
    check("arst.restart_h", int'(d_h), 1);
    check("arst.restart_act", int'(d_act), 1);
    check("arst.restart_s_h", int'(s_h), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that combines the horizontal and vertical counters into one block. It produces registered pixel coordinates, hsync/vsync with configurable polarity, an active-video flag, and line/frame boundary pulses. It sits between the system clock and the pixel/sprite renderers of the game display path. Default parameters give 640x480@60 (800x525 total).

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch
- HS_POL / VS_POL, 0 / 0, asserted level of hsync / vsync (0 = active-low)
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- PIX_DIV, 4, clocks per pixel (used only with the divider macro)
- clock, in, 1, system clock
- reset_n, in, 1, asynchronous active-low reset
- enable, in, 1, pixel advance permitted; low freezes all state
- hcount, out, CW, current horizontal position, 0..H_TOTAL-1
- vcount, out, CW, current line, 0..V_TOTAL-1
- hsync / vsync, out, 1, sync outputs at the configured polarity
- active, out, 1, high when hcount<H_ACTIVE and vcount<V_ACTIVE
- pix_tick, out, 1, internal advance strobe (adv)
- line_end, out, 1, adv & hcount==H_TOTAL-1
- frame_end, out, 1, line_end & vcount==V_TOTAL-1

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- On adv: hcount increments and wraps from H_TOTAL-1 to 0. On wrap, vcount increments and wraps from V_TOTAL-1 to 0.
- hsync is asserted while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule on vcount with the V_* parameters.
- hsync, vsync and active are registered and decoded from the next-state counter values, so they always match the hcount/vcount on the same cycle.
- line_end, frame_end and pix_tick are combinational decodes of registered state and enable only.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - hcount=0, vcount=0
  - hsync=!HS_POL, vsync=!VS_POL
  - active=0; this is the sole exception to decode alignment, so pixel (0,0) of the first frame is blanked
  - the divider is cleared
- Elaboration error if CW is too narrow or PIX_DIV < 1.

## Timing
- One counter update per adv. There is no latency between the counters and hsync/vsync/active.
- line_end is high for exactly one clock per line: the cycle in which hcount==H_TOTAL-1 and adv is high. On the next clock, hcount=0 and vcount has advanced.
- frame_end is coincident with the final line_end. Frame period is H_TOTAL*V_TOTAL advances.
- enable low: counters, divider and flags all hold, and the pulse outputs stay 0. Advancing resumes from the held value on the first clock with enable high.

## Configuration
- VGA_TIMING_PIX_DIV_EN defined:
  - an internal divider counts 0..PIX_DIV-1 on enabled clocks
  - adv = enable & (div==PIX_DIV-1)
  - after reset, the first advance occurs on the PIX_DIV-th enabled clock
- Undefined:
  - adv = enable on every clock
  - PIX_DIV is ignored and no divider logic exists

## Structure
- Package vga_timing_pkg holds:
  - the 640x480@60 constants
  - the H_TOTAL/V_TOTAL derivation functions
  - the default CW
- Sub-module vga_axis_counter contains one axis: counter, wrap, sync/active decode and a wrap output. It is instantiated twice; the horizontal wrap drives the vertical advance.

## Test plan
- Macro off, enable=1, after reset: hcount steps 0..799 and returns to 0. line_end is high only at hcount=799, and vcount goes 0→1 on the following clock.
- Sync windows: hsync is low for hcount 656..751 (96 clocks/line); vsync is low for vcount 490..491. active is high only in 0..639 x 0..479.
- Frame: frame_end is high at (799,524), the next clock gives (0,0), and frame_end recurs every 420000 clocks.
- Macro on, PIX_DIV=4: pix_tick is high 1 clock in 4, hcount advances every 4th clock, and line_end occurs every 3200 clocks.
- enable dropped for 10 clocks at hcount=300: hcount holds at 300 with no pulses, then reads 301 on the first clock after enable returns.
- reset_n asserted at (400,200) mid-clock: outputs immediately read hcount=0, vcount=0, hsync=1, vsync=1, active=0; counting restarts after release.
